pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter MDU_CYCLES, default 4, meaning total EX stall cycles per multiply/divide, legal range 2..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port ext_hold, input, 1, memory-not-ready freeze request.
REQ-005 The block SHALL have ports id_rs and id_rt, input, 5 each, source register numbers of the instruction in ID.
REQ-006 The block SHALL have port id_uses_rt, input, 1, meaning the ID instruction reads rt.
REQ-007 The block SHALL have ports ex_memread (input, 1) and ex_rt (input, 5), marking a load in EX and its destination.
REQ-008 The block SHALL have port ex_branch_taken, input, 1, meaning a branch or jump in EX resolved taken.
REQ-009 The block SHALL have port ex_mdu_start, input, 1, meaning a multiply/divide entered EX this cycle.
REQ-010 The block SHALL have load-enable outputs pc_ld, ifid_ld, idex_ld, exmem_ld and memwb_ld, output, 1 each.
REQ-011 The block SHALL have flush outputs ifid_flush, idex_flush and exmem_flush, output, 1 each; flush loads the register's Initial (bubble) value.
REQ-012 The block SHALL have port mdu_busy (output, 1) and port stall_count (output, 16), a saturating count of stall cycles.

Function
REQ-013 The block SHALL use two states, RUN and MDU_BUSY, plus a 4-bit countdown register; all outputs are combinational from state, counter and inputs.
REQ-014 load_use SHALL be ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
REQ-015 Priority in RUN SHALL be: ext_hold > ex_mdu_start > ex_branch_taken > load_use > normal.
REQ-016 Under ext_hold, in either state, all *_ld and all flushes SHALL be 0; state, counter and stall_count are frozen.
REQ-017 Normal RUN SHALL drive all *_ld = 1 and all flushes = 0.
REQ-018 On RUN with load_use: pc_ld = ifid_ld = 0, idex_flush = 1, and exmem_ld = memwb_ld = 1, giving exactly one bubble cycle.
REQ-019 On RUN with ex_branch_taken: all *_ld = 1 and ifid_flush = idex_flush = 1; any simultaneous load_use is ignored.
REQ-020 On RUN with ex_mdu_start: the block SHALL enter MDU_BUSY with counter = MDU_CYCLES-2; that cycle is stall cycle 1.
REQ-021 A stall cycle SHALL drive pc_ld = ifid_ld = idex_ld = 0, exmem_flush = 1, memwb_ld = 1 and mdu_busy = 1, both on entry and in MDU_BUSY.
REQ-022 In MDU_BUSY, the counter SHALL decrement each non-held cycle; at counter 0 the cycle is still a stall and the next state is RUN.
REQ-023 The EX instruction SHALL therefore advance exactly MDU_CYCLES cycles after the start cycle, excluding held cycles.
REQ-024 ex_branch_taken, ex_mdu_start and load_use SHALL be ignored in MDU_BUSY.
REQ-025 stall_count SHALL increment on each load-use or MDU stall cycle (not ext_hold cycles) and saturate at 0xFFFF.

Reset
REQ-026 While reset = 1, all *_ld SHALL be 0, all flushes 1, mdu_busy 0, state RUN, counter 0 and stall_count 0.
REQ-027 Reset asserted mid-MDU_BUSY SHALL abort the sequence immediately; the first cycle after deassertion is normal RUN.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state enum, the MDU_CYCLES default and the 5-bit register-number width constant.
REQ-029 The load-use compare SHALL be a combinational sub-module, hazard_detect, instantiated once.

Verification
REQ-030 Scenario load-use: ex_memread = 1, ex_rt = 5, id_rs = 5 for one cycle -> pc_ld = ifid_ld = 0 and idex_flush = 1 for 1 cycle; stall_count = 1.
REQ-031 Scenario $zero: ex_memread = 1, ex_rt = 0 = id_rs -> no stall; all ld = 1.
REQ-032 Scenario MDU: ex_mdu_start pulse with MDU_CYCLES = 4 -> mdu_busy high for 4 cycles, exmem_flush = 1 for those 4 cycles, then RUN; stall_count = 4.
REQ-033 Scenario simultaneous: ex_branch_taken plus load_use in one cycle -> ifid_flush = idex_flush = 1, pc_ld = 1, stall_count unchanged.
REQ-034 Scenario hold: ext_hold for 2 cycles inside MDU_BUSY -> all ld = 0, no flush; MDU stall extends to 6 total cycles; stall_count = 4.
REQ-035 Scenario reset: reset asserted at MDU stall cycle 2 -> outputs reach reset values asynchronously; after release, normal RUN with stall_count = 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_BUSY = 1'b1
   } pipe_state_t;

   localparam int MDU_CYCLES_DEFAULT = 4;
   localparam int REG_W              = 5;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard compare between EX load and ID sources
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             load_use
);

   // register 0 is hardwired, so a load targeting it never creates a dependency
   assign load_use = ex_memread & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for a five-stage pipeline with multi-cycle MDU
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_CYCLES = MDU_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ext_hold,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_mdu_start,
   output logic             pc_ld,
   output logic             ifid_ld,
   output logic             idex_ld,
   output logic             exmem_ld,
   output logic             memwb_ld,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             mdu_busy,
   output logic [15:0]      stall_count
);

   // entry cycle is already stall 1, so the countdown covers the remaining ones
   localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 2);

   pipe_state_t state, next_state;
   logic [3:0]  cnt, next_cnt;
   logic        load_use;
   logic        stall_inc;

   hazard_detect u_hazard (
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .load_use   (load_use)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         cnt         <= '0;
         stall_count <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         if (stall_inc && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end

   always_comb begin
      next_state  = state;
      next_cnt    = cnt;
      stall_inc   = 1'b0;
      pc_ld       = 1'b1;
      ifid_ld     = 1'b1;
      idex_ld     = 1'b1;
      exmem_ld    = 1'b1;
      memwb_ld    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      mdu_busy    = 1'b0;

      if (reset) begin
         pc_ld       = 1'b0;
         ifid_ld     = 1'b0;
         idex_ld     = 1'b0;
         exmem_ld    = 1'b0;
         memwb_ld    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (ext_hold) begin
         pc_ld    = 1'b0;
         ifid_ld  = 1'b0;
         idex_ld  = 1'b0;
         exmem_ld = 1'b0;
         memwb_ld = 1'b0;
         mdu_busy = (state == MDU_BUSY);
      end else if (state == MDU_BUSY || ex_mdu_start) begin
         // MDU stall: freeze front end, bubble into MEM, let WB drain
         pc_ld       = 1'b0;
         ifid_ld     = 1'b0;
         idex_ld     = 1'b0;
         exmem_flush = 1'b1;
         mdu_busy    = 1'b1;
         stall_inc   = 1'b1;
         if (state == RUN) begin
            next_state = MDU_BUSY;
            next_cnt   = MDU_LOAD;
         end else if (cnt == 4'd0) begin
            next_state = RUN;
         end else begin
            next_cnt = cnt - 4'd1;
         end
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_ld      = 1'b0;
         ifid_ld    = 1'b0;
         idex_flush = 1'b1;
         stall_inc  = 1'b1;
      end
   end

endmodule
